matmul_nxn_seq: RTL and testbench
=================================

Name: matmul_nxn_seq

Overview:
Parametrised sequential N x N unsigned matrix multiplier; generalises the fixed 3x3 8-bit multiplier to any N, DATA_W and OUT_W.
- Single multiply-accumulate (MAC) unit, one product per cycle; flat packed operand and result buses; start/done handshake with busy flag.
- Results are double-buffered: C_flat changes only on completion.
- Sits between the operand register file and result consumers in the matrix datapath.

Parameters:
N, 3, matrix dimension (N >= 2)
DATA_W, 8, element width of A and B (unsigned)
OUT_W, 8, element width of C; ACC_W = 2*DATA_W + clog2(N) internal accumulator width, OUT_W <= ACC_W

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE
A_flat  input  N*N*DATA_W  matrix A, row-major, element (0,0) in MSBs
B_flat  input  N*N*DATA_W  matrix B, same packing
C_flat  output  N*N*OUT_W  result C = A x B, same packing
done  output  1  one-cycle completion pulse
busy  output  1  high while a multiply is in progress

Behaviour:
- Packing: element (i,j) occupies bits [(N*N-i*N-j)*W-1 -: W], with W = DATA_W or OUT_W.
- Reset (reset low, asynchronous): state=IDLE; C_flat=0, done=0, busy=0; internal buffers, indices i/j/k and accumulator all cleared. Reset mid-operation aborts the run; no done is produced.
- States: IDLE, MAC, DONE.
- IDLE:
  - On a clock edge with start=1: capture A_flat and B_flat into internal registers; i=j=k=0; acc=0; go to MAC.
  - Input changes after the capture edge have no effect.
- MAC: busy=1. Each cycle, acc += A[i][k]*B[k][j], computed at full ACC_W.
  - When k==N-1: sum = acc + product; write fit(sum) into the result buffer at (i,j); acc=0; k=0.
  - Then advance j; wrap j to 0 and increment i.
  - After the write to (N-1,N-1), go to DONE.
- DONE: C_flat <= result buffer; done=1 and busy=0 for exactly one cycle; then IDLE.
- Latency: done is high in the cycle starting N^3+1 edges after the start-capture edge. For N=3, that is edge 28 after capture. C_flat is valid from the same cycle done is high.
- start is ignored while busy or in DONE; no queuing. If start is still high in the IDLE cycle after DONE, a new run begins.
- C_flat holds its previous result for the whole of a run and changes only on the DONE transition.
- fit(): low OUT_W bits (modulo 2^OUT_W) unless MATMUL_SAT_EN is defined.
- Arithmetic is unsigned throughout.

Optional Feature:
MATMUL_SAT_EN
- Defined: fit(sum) = (sum > 2^OUT_W-1) ? 2^OUT_W-1 : sum[OUT_W-1:0]. Adds output port sat (1 bit), reset 0, updated in DONE, high if any element saturated during the run.
- Undefined: fit() truncates (wrap-around); no sat port.

Test Plan:
- Smoke, N=3, DATA_W=OUT_W=8: A={9,8,7,6,5,4,3,2,1}, B={1,2,3,4,5,6,7,8,9}, pulse start -> done pulses once at capture+28. C={90,114,138,54,69,84,18,24,30}, MSB first.
- Overflow, all A and B elements 255:
  - Without macro -> every C element = 3 (195075 mod 256).
  - With MATMUL_SAT_EN -> every element = 255, sat=1.
- Identity, N=4, DATA_W=8, OUT_W=18: A=identity, B=1..16 -> C equals B; done at capture+65.
- Busy protection: start re-pulsed and A_flat changed mid-run -> result matches the originally captured operands; exactly one done pulse. Previous C_flat is held stable until done.
- Reset mid-run at capture+10: drive reset low for one cycle -> C_flat=0, done=0, busy=0 immediately. No done follows; a fresh start then runs to completion normally.
- Back-to-back: hold start high across two runs -> second run begins the cycle after DONE. Two done pulses spaced N^3+2 cycles apart, each with the correct C.

Source files
------------

// File: rtl/matmul_nxn_seq.sv
// rtl/matmul_nxn_seq.sv - sequential N x N unsigned matrix multiplier with a single MAC
//
// Purpose:
//   Computes C = A x B for unsigned N x N matrices, one product per clock,
//   using a single multiply-accumulate unit. Operands are captured on the
//   start edge. C_flat is double-buffered and only updates on completion.
//
// Ports:
//   clk     - system clock, rising edge
//   reset   - asynchronous active-low reset
//   start   - run request, sampled only while idle
//   A_flat  - matrix A, row-major, element (0,0) in the MSBs
//   B_flat  - matrix B, same packing
//   C_flat  - result matrix, same packing, OUT_W bits per element
//   done    - one-cycle completion pulse, C_flat valid from this cycle
//   busy    - high while products are being accumulated
//   sat     - (MATMUL_SAT_EN only) some element saturated in the last run
//
// Configuration:
//   MATMUL_SAT_EN - when defined, results clamp to 2^OUT_W-1 instead of
//                   wrapping, and the sat output port is added.

module matmul_nxn_seq #(
  parameter int N      = 3,
  parameter int DATA_W = 8,
  parameter int OUT_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [N*N*DATA_W-1:0]   A_flat,
  input  logic [N*N*DATA_W-1:0]   B_flat,
  output logic [N*N*OUT_W-1:0]    C_flat,
  output logic                    done,
  output logic                    busy
`ifdef MATMUL_SAT_EN
  ,
  output logic                    sat
`endif
);

  localparam int ACC_W = 2*DATA_W + $clog2(N);
  localparam int IDX_W = $clog2(N);
  localparam int NN    = N*N;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N-1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [NN*DATA_W-1:0]    a_q, a_d;
  logic [NN*DATA_W-1:0]    b_q, b_d;
  logic [NN*OUT_W-1:0]     res_q, res_d;
  logic [NN*OUT_W-1:0]     c_q, c_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [IDX_W-1:0]        i_q, i_d;
  logic [IDX_W-1:0]        j_q, j_d;
  logic [IDX_W-1:0]        k_q, k_d;
  logic                    done_q, done_d;

`ifdef MATMUL_SAT_EN
  logic                    sat_run_q, sat_run_d;
  logic                    sat_q, sat_d;
  logic                    ovf;
`endif

  // Element positions counted from the LSB end, since (0,0) sits in the MSBs.
  int                      a_pos;
  int                      b_pos;
  int                      r_pos;
  logic [ACC_W-1:0]        prod;
  logic [ACC_W-1:0]        sum;
  logic [OUT_W-1:0]        fit_val;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    c_d     = c_q;
    acc_d   = acc_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    done_d  = 1'b0;
`ifdef MATMUL_SAT_EN
    sat_run_d = sat_run_q;
    sat_d     = sat_q;
`endif

    a_pos = NN - 1 - (int'(i_q) * N + int'(k_q));
    b_pos = NN - 1 - (int'(k_q) * N + int'(j_q));
    r_pos = NN - 1 - (int'(i_q) * N + int'(j_q));

    prod = ACC_W'(a_q[a_pos*DATA_W +: DATA_W]) * ACC_W'(b_q[b_pos*DATA_W +: DATA_W]);
    sum  = acc_q + prod;

`ifdef MATMUL_SAT_EN
    // Any bit above OUT_W means the value does not fit; the shift form also
    // works when OUT_W == ACC_W (nothing can overflow then).
    ovf     = |(sum >> OUT_W);
    fit_val = ovf ? {OUT_W{1'b1}} : OUT_W'(sum);
`else
    fit_val = OUT_W'(sum);
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = A_flat;
          b_d     = B_flat;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
          state_d = S_MAC;
`ifdef MATMUL_SAT_EN
          sat_run_d = 1'b0;
`endif
        end
      end

      S_MAC: begin
        if (k_q == IDX_LAST) begin
          // Last product of the dot product: store the element and restart
          // the accumulator for the next (i,j).
          res_d[r_pos*OUT_W +: OUT_W] = fit_val;
          acc_d = '0;
          k_d   = '0;
`ifdef MATMUL_SAT_EN
          if (ovf) sat_run_d = 1'b1;
`endif
          if (j_q == IDX_LAST) begin
            j_d = '0;
            if (i_q == IDX_LAST) begin
              state_d = S_DONE;
            end else begin
              i_d = i_q + 1'b1;
            end
          end else begin
            j_d = j_q + 1'b1;
          end
        end else begin
          acc_d = sum;
          k_d   = k_q + 1'b1;
        end
      end

      S_DONE: begin
        c_d     = res_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
`ifdef MATMUL_SAT_EN
        sat_d   = sat_run_q;
`endif
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      c_q     <= '0;
      acc_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
`ifdef MATMUL_SAT_EN
      sat_run_q <= 1'b0;
      sat_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      done_q  <= done_d;
`ifdef MATMUL_SAT_EN
      sat_run_q <= sat_run_d;
      sat_q     <= sat_d;
`endif
    end
  end

  assign C_flat = c_q;
  assign done   = done_q;
  assign busy   = (state_q == S_MAC);
`ifdef MATMUL_SAT_EN
  assign sat    = sat_q;
`endif

endmodule

// File: tb/tb_matmul_nxn_seq.sv
// tb/tb_matmul_nxn_seq.sv - scoreboard testbench for matmul_nxn_seq (N=3/8-bit and N=4/18-bit)

module tb_matmul_nxn_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;

  // N=3, DATA_W=8, OUT_W=8 instance
  logic         start3;
  logic [71:0]  a3, b3;
  logic [71:0]  c3;
  logic         done3, busy3;
  // N=4, DATA_W=8, OUT_W=18 instance
  logic         start4;
  logic [127:0] a4, b4;
  logic [287:0] c4;
  logic         done4, busy4;
`ifdef MATMUL_SAT_EN
  logic         sat3, sat4;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  matmul_nxn_seq #(.N(3), .DATA_W(8), .OUT_W(8)) dut3 (
    .clk(clk), .reset(rst_n), .start(start3), .A_flat(a3), .B_flat(b3),
    .C_flat(c3), .done(done3), .busy(busy3)
`ifdef MATMUL_SAT_EN
    , .sat(sat3)
`endif
  );

  matmul_nxn_seq #(.N(4), .DATA_W(8), .OUT_W(18)) dut4 (
    .clk(clk), .reset(rst_n), .start(start4), .A_flat(a4), .B_flat(b4),
    .C_flat(c4), .done(done4), .busy(busy4)
`ifdef MATMUL_SAT_EN
    , .sat(sat4)
`endif
  );

  typedef struct {
    logic [71:0] c;
    int          cyc;
    logic        s;
  } exp3_t;

  typedef struct {
    logic [287:0] c;
    int           cyc;
  } exp4_t;

  exp3_t q3[$];
  exp4_t q4[$];

  // Hand-computed vectors (row-major, element (0,0) first)
  int sa[9]   = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
  int sb[9]   = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
  int sc[9]   = '{90, 114, 138, 54, 69, 84, 18, 24, 30};   // sa x sb
  int rc[9]   = '{30, 24, 18, 84, 69, 54, 138, 114, 90};   // sb x sa
  int ones[9] = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
  int twos[9] = '{2, 2, 2, 2, 2, 2, 2, 2, 2};
  int oc1[9]  = '{12, 15, 18, 12, 15, 18, 12, 15, 18};     // ones x sb
  int ff[9]   = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
`ifdef MATMUL_SAT_EN
  int ovc[9]  = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
  logic ov_sat = 1'b1;
`else
  int ovc[9]  = '{3, 3, 3, 3, 3, 3, 3, 3, 3};               // 195075 mod 256
  logic ov_sat = 1'b0;
`endif
  int ia[16]  = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int b16[16] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};

  function automatic logic [71:0] pk3(input int v[9]);
    logic [71:0] r;
    r = '0;
    for (int e = 0; e < 9; e++) r[(8-e)*8 +: 8] = 8'(v[e]);
    return r;
  endfunction

  function automatic logic [127:0] pk4_8(input int v[16]);
    logic [127:0] r;
    r = '0;
    for (int e = 0; e < 16; e++) r[(15-e)*8 +: 8] = 8'(v[e]);
    return r;
  endfunction

  function automatic logic [287:0] pk4_18(input int v[16]);
    logic [287:0] r;
    r = '0;
    for (int e = 0; e < 16; e++) r[(15-e)*18 +: 18] = 18'(v[e]);
    return r;
  endfunction

  task automatic check(input string name, input logic [287:0] got, input logic [287:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h required=%0h", name, cyc, got, req);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic run3(input logic [71:0] a, input logic [71:0] b, output int cap);
    @(negedge clk);
    a3 = a;
    b3 = b;
    start3 = 1'b1;
    @(negedge clk);
    cap = cyc;
    start3 = 1'b0;
  endtask

  task automatic push3(input logic [71:0] c, input int dcyc, input logic s);
    exp3_t e;
    e.c = c;
    e.cyc = dcyc;
    e.s = s;
    q3.push_back(e);
  endtask

  // Monitor for the N=3 instance: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done3) begin
      if (q3.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done3 cyc=%0d got done=1 required no pending result", cyc);
      end else begin
        exp3_t e;
        e = q3.pop_front();
        checks++;
        if (c3 !== e.c) begin
          errors++;
          $display("FAIL c3_result cyc=%0d got=%0h required=%0h", cyc, c3, e.c);
        end
        checks++;
        if (cyc != e.cyc) begin
          errors++;
          $display("FAIL done3_latency got cycle %0d required cycle %0d", cyc, e.cyc);
        end
`ifdef MATMUL_SAT_EN
        checks++;
        if (sat3 !== e.s) begin
          errors++;
          $display("FAIL sat3 cyc=%0d got=%0b required=%0b", cyc, sat3, e.s);
        end
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done4) begin
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done4 cyc=%0d got done=1 required no pending result", cyc);
      end else begin
        exp4_t e;
        e = q4.pop_front();
        checks++;
        if (c4 !== e.c) begin
          errors++;
          $display("FAIL c4_result cyc=%0d got=%0h required=%0h", cyc, c4, e.c);
        end
        checks++;
        if (cyc != e.cyc) begin
          errors++;
          $display("FAIL done4_latency got cycle %0d required cycle %0d", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    int cap;
    exp4_t e4;

    rst_n = 1'b0;
    start3 = 1'b0; a3 = '0; b3 = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    repeat (3) @(negedge clk);
    check("reset_c3", 288'(c3), '0);
    check("reset_done3", 288'(done3), '0);
    check("reset_busy3", 288'(busy3), '0);
    check("reset_c4", c4, '0);
    check("reset_done4", 288'(done4), '0);
    check("reset_busy4", 288'(busy4), '0);
    rst_n = 1'b1;

    // Smoke
    run3(pk3(sa), pk3(sb), cap);
    check("busy3_after_capture", 288'(busy3), 288'(1));
    push3(pk3(sc), cap + 28, 1'b0);
    wait_cyc(cap + 31);

    // Overflow
    run3(pk3(ff), pk3(ff), cap);
    push3(pk3(ovc), cap + 28, ov_sat);
    wait_cyc(cap + 31);

    // Busy protection: restart and operand change mid-run are ignored
    run3(pk3(ones), pk3(sb), cap);
    push3(pk3(oc1), cap + 28, 1'b0);
    while (cyc < cap + 31) begin
      @(negedge clk);
      if (cyc == cap + 5) begin
        start3 = 1'b1;
        a3 = pk3(twos);
      end
      if (cyc == cap + 6) begin
        start3 = 1'b0;
        check("busy3_mid_run", 288'(busy3), 288'(1));
      end
      if (cyc < cap + 28) check("c3_held", 288'(c3), 288'(pk3(ovc)));
    end

    // Reset mid-run
    run3(pk3(sa), pk3(sb), cap);
    wait_cyc(cap + 10);
    rst_n = 1'b0;
    #1;
    check("midreset_c3", 288'(c3), '0);
    check("midreset_done3", 288'(done3), '0);
    check("midreset_busy3", 288'(busy3), '0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(cyc + 35);
    run3(pk3(sb), pk3(sa), cap);
    push3(pk3(rc), cap + 28, 1'b0);
    wait_cyc(cap + 31);

    // Back-to-back with start held high
    @(negedge clk);
    a3 = pk3(sa);
    b3 = pk3(sb);
    start3 = 1'b1;
    @(negedge clk);
    cap = cyc;
    push3(pk3(sc), cap + 28, 1'b0);
    push3(pk3(rc), cap + 57, 1'b0);
    a3 = pk3(sb);
    b3 = pk3(sa);
    wait_cyc(cap + 29);
    start3 = 1'b0;
    wait_cyc(cap + 60);

    // Identity, N=4
    @(negedge clk);
    a4 = pk4_8(ia);
    b4 = pk4_8(b16);
    start4 = 1'b1;
    @(negedge clk);
    cap = cyc;
    start4 = 1'b0;
    e4.c = pk4_18(b16);
    e4.cyc = cap + 65;
    q4.push_back(e4);
    wait_cyc(cap + 70);

    check("pending3_empty", 288'(q3.size()), '0);
    check("pending4_empty", 288'(q4.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
